// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and request-control payload for the load/store unit.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCESS    = 3'd1,
        ST_RMW_READ  = 3'd2,
        ST_RMW_WRITE = 3'd3,
        ST_RESP      = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       sgn;
        logic       err;
    } lsu_ctrl_t;

    // Misaligned half/word or the reserved size code.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane extraction (with optional sign extension) and lane merge for sub-word stores.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [WORD_W-1:0] store_i,
    input  logic [1:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    output logic [WORD_W-1:0] load_c_o,
    output logic [WORD_W-1:0] merge_c_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_sh   = {offset_i, 3'b000};
        half_sh   = {offset_i[1], 4'b0000};
        byte_v    = word_i[byte_sh +: 8];
        half_v    = word_i[half_sh +: 16];
        load_c_o  = '0;
        merge_c_o = word_i;
        case (size_i)
            SIZE_BYTE: begin
                load_c_o                = {{(WORD_W-8){signed_i & byte_v[7]}}, byte_v};
                merge_c_o[byte_sh +: 8] = store_i[7:0];
            end
            SIZE_HALF: begin
                load_c_o                 = {{(WORD_W-16){signed_i & half_v[15]}}, half_v};
                merge_c_o[half_sh +: 16] = store_i[15:0];
            end
            SIZE_WORD: begin
                load_c_o  = word_i;
                merge_c_o = store_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligned word access, read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    lsu_state_e        state_q, state_d;
    lsu_ctrl_t         ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic              accept;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] merge_c;

    lsu_byte_lane u_lane (
        .word_i    (mem_rdata),
        .store_i   (wdata_q),
        .offset_i  (addr_q[1:0]),
        .size_i    (ctrl_q.size),
        .signed_i  (ctrl_q.sgn),
        .load_c_o  (load_c),
        .merge_c_o (merge_c)
    );

    assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

    // Next state and request capture; outputs are decoded from the state being entered.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_we_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    ctrl_d.write = req_write;
                    ctrl_d.size  = req_size;
                    ctrl_d.sgn   = req_signed;
                    ctrl_d.err   = req_illegal(req_size, req_addr[1:0]);
                    if (ctrl_d.err) begin
                        state_d = ST_RESP;
                    end else if (!req_write || (req_size == SIZE_WORD)) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_RMW_READ;
                    end
                end
            end
            ST_ACCESS:    state_d = ST_RESP;
            ST_RMW_READ:  state_d = ST_RMW_WRITE;
            ST_RMW_WRITE: state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: req_ready_d = 1'b1;
            ST_ACCESS: begin
                mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
                if (ctrl_d.write) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wdata_d;
                end
            end
            ST_RMW_READ: mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
            // The old word is on mem_rdata during RMW_READ; register it already merged.
            ST_RMW_WRITE: begin
                mem_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
                mem_we_d    = 1'b1;
                mem_wdata_d = merge_c;
            end
            ST_RESP: begin
                resp_valid_d = 1'b1;
                resp_error_d = ctrl_d.err;
                if ((state_q == ST_ACCESS) && !ctrl_q.write) begin
                    resp_rdata_d = load_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ctrl_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter DATA_W, default 32: memory word width; only 32 supported.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  1  CPU request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_write  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-009 SHALL have port req_signed  in  1  sign-extend sub-word loads.
REQ-010 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  in  DATA_W  store data, right-justified.
REQ-012 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  out  DATA_W  load result; 0 for stores and errors.
REQ-014 SHALL have port resp_error  out  1  misaligned or reserved-size request; valid with resp_valid.
REQ-015 SHALL have port mem_addr  out  ADDR_W  word-aligned address to data memory.
REQ-016 SHALL have port mem_rdata  in  DATA_W  combinational read data from data memory.
REQ-017 SHALL have port mem_wdata  out  DATA_W  write data to data memory.
REQ-018 SHALL have port mem_we  out  1  write enable; memory commits on the clk rising edge while high.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, and all request fields are registered at acceptance.
REQ-021 SHALL route accepted requests from IDLE as follows: misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 3 -> RESP with error; word store or any load -> ACCESS; byte/half store -> RMW_READ.
REQ-022 SHALL drive mem_addr = {addr[ADDR_W-1:2],2'b00} of the registered address in ACCESS, RMW_READ, and RMW_WRITE, and 0 otherwise.
REQ-023 SHALL, in ACCESS, capture mem_rdata into a result register for loads and assert mem_we=1 with mem_wdata=req_wdata for word stores; next state RESP.
REQ-024 SHALL, in RMW_READ, capture mem_rdata as the old word; next state RMW_WRITE.
REQ-025 SHALL, in RMW_WRITE, assert mem_we=1 with the old word and only the addressed lanes replaced (byte lane addr[1:0], half lanes addr[1]*2+{0,1}); next state RESP.
REQ-026 SHALL use little-endian lanes: byte n = bits [8n+7:8n].
REQ-027 SHALL extract loads by lane and zero-extend, or sign-extend when req_signed=1.
REQ-028 SHALL, in RESP, pulse resp_valid=1 for exactly one cycle with resp_rdata and resp_error; next state IDLE.
REQ-029 SHALL give latency from acceptance edge to resp_valid high of: error 1 cycle, load/word store 2 cycles, sub-word store 3 cycles.
REQ-030 SHALL assert mem_we for exactly one cycle per store and never for loads or errored requests; mem_wdata SHALL be 0 when mem_we=0.
REQ-031 SHALL ignore req_valid outside IDLE; there is no request queue.

Reset
REQ-032 SHALL, while reset_n=0, force state IDLE and outputs req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-033 SHALL abort an in-flight operation on reset: no mem_we or resp_valid for that request after reset_n rises; req_ready=1 in the first cycle after reset_n rises.

Structure
REQ-034 SHALL place the size encodings (SIZE_BYTE/HALF/WORD) and the FSM state enum in the shared package lsu_pkg.
REQ-035 SHALL implement lane extraction and lane merge in one combinational sub-module, lsu_byte_lane.

Verification
REQ-036 SHALL cover this scenario: word at 0x8 = 0x11223344; load byte unsigned at addr 0x9 -> resp_rdata=0x00000033, resp_valid 2 cycles after accept, mem_we never high.
REQ-037 SHALL cover this scenario: word at 0x0 = 0xAABBCCDD; load byte signed at addr 0x0 -> 0xFFFFFFDD; load half signed at addr 0x2 -> 0xFFFFAABB.
REQ-038 SHALL cover this scenario: word at 0x8 = 0x11223344; store half 0xBEEF at addr 0xA -> one mem_we cycle with mem_wdata=0xBEEF3344; memory reads 0xBEEF3344; resp_valid 3 cycles after accept.
REQ-039 SHALL cover this scenario: load word at addr 0x6 -> resp_error=1 and resp_rdata=0 one cycle after accept; no mem_we.
REQ-040 SHALL cover this scenario: store byte at 0x4; pull reset_n low during RMW_READ -> no mem_we and no resp_valid after release; memory at 0x4 unchanged.
REQ-041 SHALL cover this scenario: req_valid held high with store word 0x12345678 to 0x10, then load word from 0x10 -> second request accepted the cycle after the first resp_valid; load returns 0x12345678.
